// File: rtl/ascii_time_tx_if.sv
// Request/digit inputs and FIFO write-port outputs of the ASCII time transmitter.
// The slave modport is the transmitter side; master is the environment driving it.
interface ascii_time_tx_if;
    logic       iTime_En;
    logic       iAuto_En;
    logic       iFull;
    logic [3:0] iDigit_Hour_10;
    logic [3:0] iDigit_Hour_1;
    logic [3:0] iDigit_Min_10;
    logic [3:0] iDigit_Min_1;
    logic [3:0] iDigit_Sec_10;
    logic [3:0] iDigit_Sec_1;
    logic       oPush;
    logic [7:0] oAscii;
    logic       oBusy;

    modport master (
        output iTime_En, iAuto_En, iFull,
        output iDigit_Hour_10, iDigit_Hour_1, iDigit_Min_10,
        output iDigit_Min_1, iDigit_Sec_10, iDigit_Sec_1,
        input  oPush, oAscii, oBusy
    );

    modport slave (
        input  iTime_En, iAuto_En, iFull,
        input  iDigit_Hour_10, iDigit_Hour_1, iDigit_Min_10,
        input  iDigit_Min_1, iDigit_Sec_10, iDigit_Sec_1,
        output oPush, oAscii, oBusy
    );
endinterface

// File: rtl/ascii_time_tx.sv
// Formats a snapshot of HH:MM:SS into an ASCII frame (CR LF or LF terminated)
// and writes it byte-by-byte into a TX FIFO, stalling on the FIFO full flag.
module ascii_time_tx #(
    parameter logic [7:0] P_SEP   = 8'h3A,
    parameter bit         P_CR_EN = 1'b1
) (
    input  logic            iClk,
    input  logic            iRst,
    ascii_time_tx_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = P_CR_EN ? 4'd9 : 4'd8;

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic [3:0]  prev_sec_q, prev_sec_d;
    logic        armed_q, armed_d;
    logic        trig;
    logic        push;
    logic [7:0]  ascii;
    logic        busy;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [23:0] snap);
        logic [7:0] b;
        case (idx)
            4'd0:    b = bcd_to_ascii(snap[23:20]);
            4'd1:    b = bcd_to_ascii(snap[19:16]);
            4'd2:    b = P_SEP;
            4'd3:    b = bcd_to_ascii(snap[15:12]);
            4'd4:    b = bcd_to_ascii(snap[11:8]);
            4'd5:    b = P_SEP;
            4'd6:    b = bcd_to_ascii(snap[7:4]);
            4'd7:    b = bcd_to_ascii(snap[3:0]);
            4'd8:    b = P_CR_EN ? 8'h0D : 8'h0A;
            4'd9:    b = P_CR_EN ? 8'h0A : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Auto trigger needs one armed cycle so reset release or auto enable never fires on a stale seconds value.
    always_comb begin
        trig = bus.iTime_En |
               (bus.iAuto_En & armed_q & (bus.iDigit_Sec_1 != prev_sec_q));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        prev_sec_d = bus.iDigit_Sec_1;
        armed_d    = bus.iAuto_En;
        push       = 1'b0;
        ascii      = 8'h00;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = SEND;
                    idx_d   = 4'd0;
                    snap_d  = {bus.iDigit_Hour_10, bus.iDigit_Hour_1,
                               bus.iDigit_Min_10,  bus.iDigit_Min_1,
                               bus.iDigit_Sec_10,  bus.iDigit_Sec_1};
                end
            end
            SEND: begin
                busy  = 1'b1;
                ascii = frame_byte(idx_q, snap_q);
                push  = ~bus.iFull;
                if (push) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            snap_q     <= 24'd0;
            prev_sec_q <= 4'd0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            prev_sec_q <= prev_sec_d;
            armed_q    <= armed_d;
        end
    end

    assign bus.oPush  = push;
    assign bus.oAscii = ascii;
    assign bus.oBusy  = busy;

endmodule

// File: tb/tb_ascii_time_tx.sv
// Directed bench for ascii_time_tx: CR LF instance plus an LF-only instance.
module tb_ascii_time_tx;

    logic clk;
    logic rst;

    ascii_time_tx_if if1 ();
    ascii_time_tx_if if2 ();

    ascii_time_tx #(.P_SEP(8'h3A), .P_CR_EN(1'b1)) u_dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (if1)
    );

    ascii_time_tx #(.P_SEP(8'h3A), .P_CR_EN(1'b0)) u_dut_lf (
        .iClk (clk),
        .iRst (rst),
        .bus  (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_cr [10];
    logic [7:0] cap [32];
    int cap_n;
    int busy_n;
    int full_push;
    int first_push;
    int last_push;
    logic [7:0] stall_ascii;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_digits(input logic [3:0] h10, input logic [3:0] h1, input logic [3:0] m10,
                              input logic [3:0] m1, input logic [3:0] s10, input logic [3:0] s1);
        if1.iDigit_Hour_10 = h10; if1.iDigit_Hour_1 = h1;
        if1.iDigit_Min_10  = m10; if1.iDigit_Min_1  = m1;
        if1.iDigit_Sec_10  = s10; if1.iDigit_Sec_1  = s1;
    endtask

    task automatic fire(input bit sel);
        if (sel) if2.iTime_En = 1'b1; else if1.iTime_En = 1'b1;
        tick(1);
        if2.iTime_En = 1'b0;
        if1.iTime_En = 1'b0;
    endtask

    // Runs ncyc cycles recording pushes; optional stall, re-pulse, digit change and reset injection keyed on push count.
    task automatic capture(input bit sel, input int ncyc, input int stall_after, input int stall_len,
                           input int pulse_at, input int change_at, input int rst_at);
        int stall_left;
        bit stalled, pulsed, changed, rsted;
        logic p, b, f;
        logic [7:0] a;
        stall_left = 0; stalled = 0; pulsed = 0; changed = 0; rsted = 0;
        cap_n = 0; busy_n = 0; full_push = 0; first_push = -1; last_push = -1;
        stall_ascii = 8'hxx;
        for (int i = 0; i < 32; i++) cap[i] = 8'hxx;
        for (int c = 0; c < ncyc; c++) begin
            if (pulse_at >= 0 && !pulsed && cap_n == pulse_at) begin
                if1.iTime_En = 1'b1; pulsed = 1;
            end else begin
                if1.iTime_En = 1'b0;
            end
            if (change_at >= 0 && !changed && cap_n == change_at) begin
                if1.iDigit_Sec_1 = 4'd7; if1.iDigit_Hour_10 = 4'd9; changed = 1;
            end
            if (rst_at >= 0 && !rsted && cap_n == rst_at) begin
                rst = 1'b1; rsted = 1;
            end else begin
                rst = 1'b0;
            end
            if (stall_after >= 0 && !stalled && cap_n == stall_after && stall_len > 0) begin
                if1.iFull = 1'b1; if2.iFull = 1'b1;
                stall_left = stall_len; stalled = 1;
            end
            @(negedge clk);
            p = sel ? if2.oPush  : if1.oPush;
            b = sel ? if2.oBusy  : if1.oBusy;
            a = sel ? if2.oAscii : if1.oAscii;
            f = sel ? if2.iFull  : if1.iFull;
            if (b) busy_n++;
            if (b && f) stall_ascii = a;
            if (p) begin
                if (f) full_push++;
                if (cap_n < 32) cap[cap_n] = a;
                cap_n++;
                if (first_push < 0) first_push = c;
                last_push = c;
            end
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    if1.iFull = 1'b0; if2.iFull = 1'b0;
                end
            end
        end
        if1.iTime_En = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if1.iTime_En = 1'b1;
        if2.iTime_En = 1'b1;
        tick(3);
        @(negedge clk);
        total++;
        if (if1.oPush !== 1'b0) begin bad++; $display("FAIL reset_push got=%b want=0", if1.oPush); end
        total++;
        if (if1.oAscii !== 8'h00) begin bad++; $display("FAIL reset_ascii got=%h want=00", if1.oAscii); end
        total++;
        if (if1.oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", if1.oBusy); end
        total++;
        if (if2.oBusy !== 1'b0 || if2.oPush !== 1'b0) begin
            bad++; $display("FAIL reset_lf busy=%b push=%b want=0/0", if2.oBusy, if2.oPush);
        end
        @(posedge clk);
        #1;
        if1.iTime_En = 1'b0;
        if2.iTime_En = 1'b0;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        tick(2);
        fire(1'b0);
        capture(1'b0, 14, -1, 0, -1, -1, -1);
        total++;
        if (cap_n !== 10) begin bad++; $display("FAIL basic_count got=%0d want=10", cap_n); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (cap[i] !== exp_cr[i]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, cap[i], exp_cr[i]); end
        end
        total++;
        if (first_push !== 0 || last_push !== 9) begin
            bad++; $display("FAIL basic_timing first=%0d last=%0d want=0/9", first_push, last_push);
        end
        total++;
        if (busy_n !== 10) begin bad++; $display("FAIL basic_busy got=%0d want=10", busy_n); end
    endtask

    task automatic test_stall();
        fire(1'b0);
        capture(1'b0, 18, 4, 3, -1, -1, -1);
        total++;
        if (cap_n !== 10) begin bad++; $display("FAIL stall_count got=%0d want=10", cap_n); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (cap[i] !== exp_cr[i]) begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", i, cap[i], exp_cr[i]); end
        end
        total++;
        if (full_push !== 0) begin bad++; $display("FAIL stall_push_when_full got=%0d want=0", full_push); end
        total++;
        if (busy_n !== 13 || last_push !== 12) begin
            bad++; $display("FAIL stall_length busy=%0d last=%0d want=13/12", busy_n, last_push);
        end
        total++;
        if (stall_ascii !== 8'h34) begin bad++; $display("FAIL stall_ascii_held got=%h want=34", stall_ascii); end
    endtask

    task automatic test_auto();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7);
        if1.iAuto_En = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        capture(1'b0, 10, -1, 0, -1, -1, -1);
        total++;
        if (cap_n !== 0) begin bad++; $display("FAIL auto_reset_release pushes=%0d want=0", cap_n); end
        if1.iAuto_En = 1'b0;
        tick(3);
        if1.iAuto_En = 1'b1;
        if1.iDigit_Sec_1 = 4'd0;
        capture(1'b0, 10, -1, 0, -1, -1, -1);
        total++;
        if (cap_n !== 0) begin bad++; $display("FAIL auto_enable_rise pushes=%0d want=0", cap_n); end
        if1.iDigit_Sec_1 = 4'd1;
        capture(1'b0, 50, -1, 0, -1, -1, -1);
        total++;
        if (cap_n !== 10 || cap[7] !== 8'h31 || cap[8] !== 8'h0D || cap[9] !== 8'h0A) begin
            bad++; $display("FAIL auto_sec1 count=%0d b7=%h b8=%h b9=%h want=10/31/0d/0a", cap_n, cap[7], cap[8], cap[9]);
        end
        if1.iDigit_Sec_1 = 4'd2;
        capture(1'b0, 50, -1, 0, -1, -1, -1);
        total++;
        if (cap_n !== 10 || cap[7] !== 8'h32 || cap[0] !== 8'h31) begin
            bad++; $display("FAIL auto_sec2 count=%0d b0=%h b7=%h want=10/31/32", cap_n, cap[0], cap[7]);
        end
        if1.iAuto_En = 1'b0;
        tick(2);
    endtask

    task automatic test_retrigger();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        if1.iAuto_En = 1'b1;
        tick(3);
        fire(1'b0);
        capture(1'b0, 30, -1, 0, 4, 6, -1);
        total++;
        if (cap_n !== 10) begin bad++; $display("FAIL retrig_count got=%0d want=10", cap_n); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (cap[i] !== exp_cr[i]) begin bad++; $display("FAIL retrig_byte%0d got=%h want=%h", i, cap[i], exp_cr[i]); end
        end
        if1.iAuto_En = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        tick(2);
    endtask

    task automatic test_back_to_back();
        fire(1'b0);
        capture(1'b0, 30, -1, 0, 9, -1, -1);
        total++;
        if (cap_n !== 10) begin bad++; $display("FAIL b2b_drop_last count=%0d want=10", cap_n); end
        fire(1'b0);
        capture(1'b0, 30, -1, 0, 10, -1, -1);
        total++;
        if (cap_n !== 20 || last_push !== 20 || busy_n !== 20) begin
            bad++; $display("FAIL b2b_spacing count=%0d last=%0d busy=%0d want=20/20/20", cap_n, last_push, busy_n);
        end
        total++;
        if (cap[10] !== 8'h31 || cap[19] !== 8'h0A) begin
            bad++; $display("FAIL b2b_second_frame b10=%h b19=%h want=31/0a", cap[10], cap[19]);
        end
    endtask

    task automatic test_reset_mid();
        fire(1'b0);
        capture(1'b0, 12, -1, 0, -1, -1, 2);
        total++;
        if (cap_n !== 3 || busy_n !== 3) begin
            bad++; $display("FAIL rstmid_abort pushes=%0d busy=%0d want=3/3", cap_n, busy_n);
        end
        fire(1'b0);
        capture(1'b0, 14, -1, 0, -1, -1, -1);
        total++;
        if (cap_n !== 10) begin bad++; $display("FAIL rstmid_refire count=%0d want=10", cap_n); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (cap[i] !== exp_cr[i]) begin bad++; $display("FAIL rstmid_byte%0d got=%h want=%h", i, cap[i], exp_cr[i]); end
        end
    endtask

    task automatic test_lf_only();
        logic [7:0] exp_lf [9];
        exp_lf = '{8'h3F, 8'h31, 8'h3A, 8'h32, 8'h33, 8'h3A, 8'h34, 8'h35, 8'h0A};
        if2.iDigit_Hour_10 = 4'hC; if2.iDigit_Hour_1 = 4'd1;
        if2.iDigit_Min_10  = 4'd2; if2.iDigit_Min_1  = 4'd3;
        if2.iDigit_Sec_10  = 4'd4; if2.iDigit_Sec_1  = 4'd5;
        tick(2);
        fire(1'b1);
        capture(1'b1, 14, -1, 0, -1, -1, -1);
        total++;
        if (cap_n !== 9 || busy_n !== 9) begin
            bad++; $display("FAIL lf_count pushes=%0d busy=%0d want=9/9", cap_n, busy_n);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (cap[i] !== exp_lf[i]) begin bad++; $display("FAIL lf_byte%0d got=%h want=%h", i, cap[i], exp_lf[i]); end
        end
    endtask

    initial begin
        exp_cr = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
        rst = 1'b1;
        if1.iTime_En = 1'b0; if1.iAuto_En = 1'b0; if1.iFull = 1'b0;
        if2.iTime_En = 1'b0; if2.iAuto_En = 1'b0; if2.iFull = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        if2.iDigit_Hour_10 = 4'd0; if2.iDigit_Hour_1 = 4'd0;
        if2.iDigit_Min_10  = 4'd0; if2.iDigit_Min_1  = 4'd0;
        if2.iDigit_Sec_10  = 4'd0; if2.iDigit_Sec_1  = 4'd0;
        tick(1);

        test_reset();
        test_basic();
        test_stall();
        test_auto();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_lf_only();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
